// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M mul/div (radix-2 shift-add, restoring divide); ALU_MULDIV_EARLY_EN enables special-case shortcut.
// Latency: XLEN+1 cycles from accept to out_valid (1 cycle for special cases when ALU_MULDIV_EARLY_EN is defined).
// Backpressure: accepts only in IDLE; the result is held in DONE until out_ready; flush aborts the op from any state.
module alu_muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       sa;
    logic       sb;
    logic       spec;
  } ctx_t;

  localparam logic [2:0]      OP_MULH   = 3'b001;
  localparam logic [2:0]      OP_MULHSU = 3'b010;
  localparam logic [2:0]      OP_DIV    = 3'b100;
  localparam logic [2:0]      OP_REM    = 3'b110;
  localparam logic [XLEN-1:0] XMIN      = {1'b1, {(XLEN-1){1'b0}}};

  state_t                state, state_nxt;
  ctx_t                  ctx;
  logic [2*XLEN-1:0]     acc, acc_step, prod;
  logic [XLEN-1:0]       opb, spec_val, in_spec_val, mag_a, mag_b, quo, rem, fix_val;
  logic [CNT_W-1:0]      cnt;
  logic                  a_signed, b_signed, in_sa, in_sb, in_special, accept, early;
  logic [XLEN:0]         mul_sum, div_shift;
  logic [XLEN+1:0]       div_diff;
  logic                  div_borrow;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_MULDIV_EARLY_EN
  assign early = in_special;
`else
  assign early = 1'b0;
`endif

  // Operand decode: signedness per funct3, magnitudes, and special results.
  always_comb begin
    a_signed    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    in_sa       = a_signed & rs1[XLEN-1];
    in_sb       = b_signed & rs2[XLEN-1];
    mag_a       = in_sa ? -rs1 : rs1;
    mag_b       = in_sb ? -rs2 : rs2;
    in_special  = 1'b0;
    in_spec_val = '0;
    if (op[2]) begin
      if (rs2 == '0) begin
        in_special  = 1'b1;
        in_spec_val = op[1] ? rs1 : '1;
      end else if (!op[0] && rs1 == XMIN && rs2 == '1) begin
        in_special  = 1'b1;
        in_spec_val = op[1] ? '0 : rs1;
      end
    end else if (rs1 == '0 || rs2 == '0) begin
      in_special = 1'b1;
    end
  end

  // One iteration: acc = {hi, lo}; multiply shifts the multiplier out of lo,
  // divide shifts the dividend out of lo into the partial remainder in hi.
  always_comb begin
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift  = acc[2*XLEN-1:XLEN-1];
    div_diff   = {1'b0, div_shift} - {2'b00, opb};
    div_borrow = div_diff[XLEN+1];
    if (ctx.op[2])
      acc_step = {(div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]), acc[XLEN-2:0], ~div_borrow};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod = (ctx.sa ^ ctx.sb) ? -acc : acc;
    quo  = (ctx.sa ^ ctx.sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = ctx.sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (ctx.spec)
      fix_val = spec_val;
    else if (ctx.op[2])
      fix_val = ctx.op[1] ? rem : quo;
    else
      fix_val = (ctx.op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = early ? S_DONE : S_CALC;
      S_CALC:  if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  if (out_valid && out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx       <= '0;
      spec_val  <= '0;
      opb       <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          ctx      <= '{op: op, sa: in_sa, sb: in_sb, spec: in_special};
          spec_val <= in_spec_val;
          opb      <= op[2] ? mag_b : mag_a;
          acc      <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
          cnt      <= CNT_W'(XLEN);
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
        end
        S_DONE: begin
          // First DONE cycle registers the fixed-up result; then wait for the consumer.
          if (!out_valid) begin
            result    <= fix_val;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Scoreboard bench for alu_muldiv_iter: arithmetic, special cases, latency, backpressure, flush and reset.
module tb_alu_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  alu_muldiv_iter #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic signed [31:0] sq, sr;
    logic ovf;
    ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
    eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
    p   = ea * eb;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    sq  = 0;
    sr  = 0;
    if (b != 0 && !ovf) begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
    end
    case (f)
      3'd0:    return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return sq;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return sr;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MULDIV_EARLY_EN
    logic sp;
    if (f[2]) sp = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else      sp = (a == 0) || (b == 0);
    return sp ? 1 : 33;
`else
    return (f == 3'd0 && a == 32'd1 && b == 32'd1) ? 33 : 33;
`endif
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit keep);
    int n;
    @(negedge clk);
    op = f; rs1 = a; rs2 = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    exp_q.push_back(model(f, a, b));
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic collect(input int want_lat, input int hold, input string name);
    int lat;
    logic [31:0] r0, e;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != want_lat) begin
      bad++;
      $display("FAIL %s_latency: got=%0d required=%0d", name, lat, want_lat);
    end
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || result !== r0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_hold: out_valid=%0b result=%h in_ready=%0b required 1/%h/0",
                 name, out_valid, result, in_ready, r0);
      end
    end
    out_ready = 1'b1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard: result=%h with empty queue", name, result);
    end else begin
      e = exp_q.pop_front();
      if (result !== e) begin
        bad++;
        $display("FAIL %s_result: got=%h required=%h", name, result, e);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input int hold, input string name);
    issue(f, a, b, 1'b0);
    collect(exp_lat(f, a, b), hold, name);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b result=%h required 1/0/0/0",
               in_ready, out_valid, busy, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7x-3");
    run(3'd1, 32'd7, 32'hFFFF_FFFD, 0, "mulh_7x-3");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 0, "mulhsu_-1x2");
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
    for (int i = 0; i < 4; i++)
      run(3'($urandom_range(0, 3)), $urandom | 32'd1, $urandom | 32'd1, 0, "mul_rand");
  endtask

  task automatic test_div();
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_-7/2");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_-7/2");
    run(3'd5, 32'd100, 32'd7, 0, "divu_100/7");
    run(3'd7, 32'd100, 32'd7, 0, "remu_100/7");
    run(3'd6, 32'd7, 32'hFFFF_FFFE, 0, "rem_7/-2");
    for (int i = 0; i < 4; i++)
      run(3'($urandom_range(4, 7)), $urandom, 32'($urandom_range(1, 5000)), 0, "div_rand");
  endtask

  task automatic test_special();
    run(3'd4, 32'd1234, 32'd0, 0, "div_by0");
    run(3'd6, 32'hFFFF_FF00, 32'd0, 0, "rem_by0");
    run(3'd5, 32'd55, 32'd0, 0, "divu_by0");
    run(3'd7, 32'd55, 32'd0, 0, "remu_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_noovf");
    run(3'd1, 32'd0, 32'hFFFF_FFFF, 0, "mulh_zero");
  endtask

  task automatic test_backpressure();
    run(3'd5, 32'd1000, 32'd3, 5, "bp_divu");
  endtask

  task automatic test_flush_reset();
    logic [31:0] prev;
    int seen;
    issue(3'd5, 32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    prev = result;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_back());
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || result !== prev) begin
      bad++;
      $display("FAIL flush_calc: busy=%0b out_valid=%0b in_ready=%0b result=%h required 0/0/1/%h",
               busy, out_valid, in_ready, result, prev);
    end
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_blocks_accept: busy=%0b required=0", busy);
    end
    issue(3'd0, 32'd3, 32'd5, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL reset_midop: in_ready=%0b busy=%0b out_valid=%0b result=%h required 1/0/0/0",
               in_ready, busy, out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL no_partial_result: out_valid cycles=%0d required=0", seen);
    end
    run(3'd5, 32'd9, 32'd3, 0, "divu_after_reset");
  endtask

  task automatic test_back_to_back();
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    op = 3'd7; rs1 = 32'd50; rs2 = 32'd8;
    collect(exp_lat(3'd1, 32'hDEAD_BEEF, 32'h1234_5678), 2, "b2b_first");
    @(posedge clk);
    exp_q.push_back(model(3'd7, 32'd50, 32'd8));
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%0b required=1", busy);
    end
    collect(exp_lat(3'd7, 32'd50, 32'd8), 0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
